// File: rtl/rotary_dial_decoder.sv
// rotary_dial_decoder
//
// Front end for the vault controller. It turns the raw quadrature pins of
// the safe dial into a registered dial position and a turning direction.
//
// Signal path: 2-flop synchronisers on every input, then a per-pin debounce
// filter on A and B, then a quadrature state machine that accumulates a
// signed sub-count and completes a detent on entry to a detent state. The
// index switch bypasses debounce and zeroes the position on its rising edge.
//
// Ports
//   clock       in   system clock
//   n_reset     in   asynchronous, active-low reset
//   enc_a       in   encoder channel A (asynchronous, bouncy)
//   enc_b       in   encoder channel B (asynchronous, bouncy)
//   enc_index   in   dial-zero index switch (asynchronous, active-high)
//   vault_code  out  current dial position, registered
//   direction   out  direction of last completed detent, 1 = up/clockwise
//   step        out  one-cycle pulse when vault_code moves by a detent
//   enc_error   out  one-cycle pulse on an illegal quadrature transition

module rotary_dial_decoder #(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = 5
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_index,
    output logic [POS_WIDTH-1:0] vault_code,
    output logic                 direction,
    output logic                 step,
    output logic                 enc_error
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0] SUB_LIMIT = 4'(STEPS_PER_DETENT);

    // State names follow the debounced {A,B} pair so the register doubles as
    // "previous debounced value" for edge detection.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_state_t;

    // Bit order in the synchroniser vectors: {index, b, a}
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic       index_prev;

    logic             deb_a;
    logic             deb_b;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    quad_state_t            state;
    quad_state_t            state_next;
    logic signed [3:0]      sub;
    logic signed [3:0]      sub_next;
    logic signed [3:0]      sub_step;
    logic [POS_WIDTH-1:0]   vault_next;
    logic                   dir_next;
    logic                   step_next;
    logic                   err_next;
    logic                   move_up;
    logic                   move_down;
    logic                   illegal;
    logic                   detent_entry;
    logic                   index_rise;

    // Two-flop synchronisers plus a delayed copy of the synchronised index
    // for rising-edge detection.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync1      <= 3'b000;
            sync2      <= 3'b000;
            index_prev <= 1'b0;
        end else begin
            sync1      <= {enc_index, enc_b, enc_a};
            sync2      <= sync1;
            index_prev <= sync2[2];
        end
    end

    // Debounce: a pin is accepted only after it has differed from its
    // debounced value for DEBOUNCE_CYCLES consecutive cycles; any return to
    // the old level restarts the count.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            deb_a <= 1'b0;
            deb_b <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (sync2[0] == deb_a) begin
                cnt_a <= '0;
            end else if (cnt_a == CNT_MAX) begin
                deb_a <= sync2[0];
                cnt_a <= '0;
            end else begin
                cnt_a <= cnt_a + 1'b1;
            end

            if (sync2[1] == deb_b) begin
                cnt_b <= '0;
            end else if (cnt_b == CNT_MAX) begin
                deb_b <= sync2[1];
                cnt_b <= '0;
            end else begin
                cnt_b <= cnt_b + 1'b1;
            end
        end
    end

    // Quadrature state, sub-count and all outputs are plain registers fed by
    // the next-state logic below.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= S00;
            sub        <= 4'sd0;
            vault_code <= '0;
            direction  <= 1'b0;
            step       <= 1'b0;
            enc_error  <= 1'b0;
        end else begin
            state      <= state_next;
            sub        <= sub_next;
            vault_code <= vault_next;
            direction  <= dir_next;
            step       <= step_next;
            enc_error  <= err_next;
        end
    end

    // Next-state logic. The debounced pair is the next state; the old/new
    // pair decides whether this was an up, down, illegal or null transition.
    // A rising index overrides any detent completing in the same cycle.
    always_comb begin
        state_next   = quad_state_t'({deb_a, deb_b});
        sub_next     = sub;
        vault_next   = vault_code;
        dir_next     = direction;
        step_next    = 1'b0;
        err_next     = 1'b0;
        move_up      = 1'b0;
        move_down    = 1'b0;

        case (state)
            S00: begin move_up = (state_next == S01); move_down = (state_next == S10); end
            S01: begin move_up = (state_next == S11); move_down = (state_next == S00); end
            S11: begin move_up = (state_next == S10); move_down = (state_next == S01); end
            S10: begin move_up = (state_next == S00); move_down = (state_next == S11); end
            default: begin move_up = 1'b0; move_down = 1'b0; end
        endcase

        illegal      = ((state ^ state_next) == 2'b11);
        detent_entry = (state_next == S00) ||
                       ((STEPS_PER_DETENT == 2) && (state_next == S11));
        sub_step     = move_up ? (sub + 4'sd1) : (sub - 4'sd1);
        index_rise   = sync2[2] & ~index_prev;

        if (illegal) begin
            sub_next = 4'sd0;
            err_next = 1'b1;
        end else if (move_up || move_down) begin
            if (detent_entry) begin
                sub_next = 4'sd0;
                if (sub_step == SUB_LIMIT) begin
                    vault_next = vault_code + POS_WIDTH'(1);
                    dir_next   = 1'b1;
                    step_next  = 1'b1;
                end else if (sub_step == -SUB_LIMIT) begin
                    vault_next = vault_code - POS_WIDTH'(1);
                    dir_next   = 1'b0;
                    step_next  = 1'b1;
                end
            end else begin
                sub_next = sub_step;
            end
        end

        if (index_rise) begin
            vault_next = '0;
            sub_next   = 4'sd0;
            dir_next   = direction;
            step_next  = 1'b0;
        end
    end

endmodule
